// File: rtl/core_pkg.sv
// core_pkg: shared fetch types and constants
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic {BOOT, FETCH} fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory request/response bus
interface fetch_unit_if;
  import core_pkg::*;
  logic req;
  logic gnt;
  logic [XLEN-1:0] addr;
  logic rvalid;
  logic [XLEN-1:0] rdata;
  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush and occupancy count
module fetch_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic take;
  assign take = pop && count != 0;
  assign dout = mem[rd];
  // storage is not reset; the count alone decides what is valid
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= din;
  // pointers and count; flush empties the queue and drops a same-cycle push
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      wr <= push ? wr + 1'b1 : wr;
      rd <= take ? rd + 1'b1 : rd;
      count <= count + CW'(push) - CW'(take);
    end
  overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && !take && count == CW'(DEPTH)));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, imem requester and in-order instruction buffer (option FETCH_PERF_EN adds perf counters)
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  fetch_unit_if.master imem,
  input  logic redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic instr_valid,
  input  logic instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic misalign
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_killed
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t state;
  logic [XLEN-1:0] pc, pc_tag;
  logic [CW-1:0] outstanding, fifo_count, kill;
  logic [CW:0] credit;
  logic [2*XLEN-1:0] head;
  logic issue, push, pop;
  assign credit = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem.req = state == FETCH && credit < (CW+1)'(FIFO_DEPTH) && !redirect;
  assign imem.addr = pc;
  assign issue = imem.req && imem.gnt;
  assign push = imem.rvalid && kill == 0 && !redirect;
  assign instr_valid = fifo_count != 0;
  assign pop = instr_valid && instr_ready;
  assign instr = instr_valid ? head[2*XLEN-1:XLEN] : NOP_INSTR;
  assign instr_pc = instr_valid ? head[XLEN-1:0] : RESET_PC;
  fetch_fifo #(.W(XLEN), .DEPTH(FIFO_DEPTH)) addr_q (
    .clk(clk), .rst(rst), .flush(1'b0), .push(issue), .pop(imem.rvalid),
    .din(pc), .dout(pc_tag), .count(outstanding)
  );
  fetch_fifo #(.W(2*XLEN), .DEPTH(FIFO_DEPTH)) instr_q (
    .clk(clk), .rst(rst), .flush(redirect), .push(push), .pop(pop),
    .din({imem.rdata, pc_tag}), .dout(head), .count(fifo_count)
  );
  // FSM, PC and kill count; redirect wins and kills whatever stays in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= BOOT;
      pc <= RESET_PC;
      kill <= '0;
      misalign <= 1'b0;
    end else begin
      state <= FETCH;
      misalign <= redirect && redirect_pc[1:0] != 2'b00;
      pc <= redirect ? {redirect_pc[XLEN-1:2], 2'b00} : issue ? pc + 32'd4 : pc;
      kill <= redirect ? outstanding - CW'(imem.rvalid) : (imem.rvalid && kill != 0) ? kill - 1'b1 : kill;
    end
`ifdef FETCH_PERF_EN
  logic [CW:0] killed_now;
  logic [32:0] f_sum, k_sum;
  // words lost this cycle: flushed entries plus a dropped or killed response
  always_comb begin
    killed_now = redirect ? {1'b0, fifo_count} - (CW+1)'(pop) + (CW+1)'(imem.rvalid)
                          : (CW+1)'(imem.rvalid && kill != 0);
    f_sum = {1'b0, perf_fetched} + 33'(push);
    k_sum = {1'b0, perf_killed} + 33'(killed_now);
  end
  // saturating performance counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_fetched <= '0;
      perf_killed <= '0;
    end else begin
      perf_fetched <= f_sum[32] ? '1 : f_sum[31:0];
      perf_killed <= k_sum[32] ? '1 : k_sum[31:0];
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed checks of fetch_unit against a stream-level model
module tb_fetch_unit;
  localparam int FIFO_DEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic instr_valid, instr_ready, misalign;
  logic [31:0] instr, instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_killed;
`endif
  fetch_unit_if imem();
  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .imem(imem), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .misalign(misalign)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_killed(perf_killed)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] a; int c;} mreq_t;
  mreq_t mq[$];
  int errors = 0, checks = 0, cyc = 0, pops = 0;
  int p_gnt = 100, p_ready = 100, p_rv = 100, p_redir = 0;
  logic force_redir = 1'b0;
  logic [31:0] force_tgt = '0;
  logic [31:0] exp_pc = '0, exp_ia = '0;
  logic mis_exp = 1'b0, prev_redir = 1'b0;
  function automatic logic [31:0] word_at(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    logic rsp;
    @(negedge clk);
    cyc++;
    imem.gnt = $urandom_range(1, 100) <= p_gnt;
    instr_ready = $urandom_range(1, 100) <= p_ready;
    if (force_redir) begin
      redirect = 1'b1;
      redirect_pc = force_tgt;
      force_redir = 1'b0;
    end else begin
      redirect = $urandom_range(1, 100) <= p_redir;
      redirect_pc = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0)};
    end
    rsp = mq.size() > 0 && mq[0].c < cyc && $urandom_range(1, 100) <= p_rv;
    imem.rvalid = rsp;
    imem.rdata = rsp ? word_at(mq[0].a) : $urandom;
    #1;
    chk("misalign", misalign, mis_exp);
    if (prev_redir) chk("flush_valid", instr_valid, 0);
    if (redirect) chk("req_on_redirect", imem.req, 0);
    if (imem.req) begin
      chk("addr", imem.addr, exp_ia);
      if (imem.gnt) begin
        mq.push_back('{imem.addr, cyc});
        exp_ia += 32'd4;
      end
    end
    chk("inflight", mq.size() <= FIFO_DEPTH, 1);
    if (rsp) void'(mq.pop_front());
    if (instr_valid && instr_ready) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr", instr, word_at(exp_pc));
      exp_pc += 32'd4;
      pops++;
    end
    if (redirect) begin
      exp_pc = {redirect_pc[31:2], 2'b00};
      exp_ia = exp_pc;
    end
    mis_exp = redirect && redirect_pc[1:0] != 2'b00;
    prev_redir = redirect;
  endtask
  task automatic model_reset();
    mq.delete();
    exp_pc = '0;
    exp_ia = '0;
    mis_exp = 1'b0;
    prev_redir = 1'b0;
    redirect = 1'b0;
    imem.rvalid = 1'b0;
  endtask
  task automatic chk_reset_outputs(string tag);
    chk({tag, "_req"}, imem.req, 0);
    chk({tag, "_addr"}, imem.addr, 32'h0);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_instr"}, instr, 32'h0000_0013);
    chk({tag, "_pc"}, instr_pc, 32'h0);
    chk({tag, "_mis"}, misalign, 0);
  endtask
  initial begin
    int first;
    imem.gnt = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata = '0;
    instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_outputs("reset");
    rst = 1'b0;
    first = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (instr_valid && first < 0) first = i;
    end
    chk("first_valid", first, 3);
    p_ready = 0;
    repeat (10) step();
    chk("full_req", imem.req, 0);
    chk("full_valid", instr_valid, 1);
    p_ready = 100;
    repeat (6) step();
    p_rv = 0;
    repeat (3) step();
    force_redir = 1'b1;
    force_tgt = 32'h100;
    step();
    p_rv = 100;
    repeat (8) step();
    p_gnt = 0;
    repeat (5) step();
    chk("stall_req", imem.req, 1);
    force_redir = 1'b1;
    force_tgt = 32'h200;
    step();
    step();
    chk("stall_redirect_addr", imem.addr, 32'h200);
    p_gnt = 100;
    repeat (6) step();
    force_redir = 1'b1;
    force_tgt = 32'h102;
    step();
    step();
    chk("misalign_pulse", misalign, 1);
    repeat (6) step();
    p_ready = 0;
    repeat (6) step();
    chk("prefull_valid", instr_valid, 1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    p_ready = 100;
    first = -1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (instr_valid && first < 0) first = i;
    end
    chk("refetch_first_valid", first, 3);
    p_gnt = 70;
    p_ready = 60;
    p_rv = 60;
    p_redir = 5;
    repeat (3000) step();
    chk("progress", pops > 500, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
